strength_bus_resolver: RTL

Parametrised multi-driver net resolver that models Verilog strength-qualified wired nets in synthesizable RTL, such as a net declared with (strong1, pull0).
- N_DRV drivers each present a WIDTH-bit value, an enable, and separate strength-0 and strength-1 codes.
- Per bit, the block resolves the winning value, conflict (X) and undriven (Z) states, and registers the result.
- A contention monitor FSM counts consecutive conflict cycles and raises a sticky fault.
- Used as the reference model and datapath for strength-specifier feature tests.

---
 rtl/strength_pkg.sv | 34 +++
 rtl/strength_bit_resolver.sv | 40 ++++
 rtl/strength_bus_resolver.sv | 136 +++++++++++++
 3 files changed

// File: rtl/strength_pkg.sv
// Shared strength codes, FSM states and the per-driver effective-strength helper.
package strength_pkg;

    localparam int unsigned STRENGTH_W = 3;

    typedef enum logic [STRENGTH_W-1:0] {
        ST_HIGHZ  = 3'd0,
        ST_SMALL  = 3'd1,
        ST_MEDIUM = 3'd2,
        ST_WEAK   = 3'd3,
        ST_LARGE  = 3'd4,
        ST_PULL   = 3'd5,
        ST_STRONG = 3'd6,
        ST_SUPPLY = 3'd7
    } strength_e;

    typedef enum logic [1:0] {
        OK      = 2'd0,
        CONTEND = 2'd1,
        FAULT   = 2'd2
    } fsm_e;

    // Strength a single driver bit contributes; a disabled driver contributes highz.
    function automatic logic [STRENGTH_W-1:0] eff_strength(
        input logic                  val,
        input logic [STRENGTH_W-1:0] s0,
        input logic [STRENGTH_W-1:0] s1,
        input logic                  en
    );
        if (!en) return STRENGTH_W'(ST_HIGHZ);
        return val ? s1 : s0;
    endfunction

endpackage

// File: rtl/strength_bit_resolver.sv
// Combinational resolution of one net bit driven by N_DRV strength-qualified drivers.
module strength_bit_resolver
    import strength_pkg::*;
#(
    parameter int unsigned N_DRV = 4
) (
    input  logic [N_DRV-1:0]            val,
    input  logic [N_DRV*STRENGTH_W-1:0] s0,
    input  logic [N_DRV*STRENGTH_W-1:0] s1,
    input  logic [N_DRV-1:0]            en,
    output logic                        drive1,
    output logic                        conflict,
    output logic                        undriven
);

    // Running maxima of the strengths pulling towards 1 and towards 0.
    logic [STRENGTH_W-1:0] m1_chain [N_DRV+1];
    logic [STRENGTH_W-1:0] m0_chain [N_DRV+1];
    logic [STRENGTH_W-1:0] eff      [N_DRV];

    assign m1_chain[0] = '0;
    assign m0_chain[0] = '0;

    for (genvar i = 0; i < N_DRV; i++) begin : g_drv
        assign eff[i] = eff_strength(val[i],
                                     s0[i*STRENGTH_W +: STRENGTH_W],
                                     s1[i*STRENGTH_W +: STRENGTH_W],
                                     en[i]);
        assign m1_chain[i+1] = (val[i] && (eff[i] > m1_chain[i])) ? eff[i] : m1_chain[i];
        assign m0_chain[i+1] = (!val[i] && (eff[i] > m0_chain[i])) ? eff[i] : m0_chain[i];
    end

    // Strongest side wins; equal non-zero strengths conflict; all-zero is undriven.
    always_comb begin
        drive1   = m1_chain[N_DRV] > m0_chain[N_DRV];
        conflict = (m1_chain[N_DRV] == m0_chain[N_DRV]) && (m1_chain[N_DRV] != '0);
        undriven = (m1_chain[N_DRV] == '0) && (m0_chain[N_DRV] == '0);
    end

endmodule

// File: rtl/strength_bus_resolver.sv
// Registered multi-driver strength-resolved bus with a contention monitor.
module strength_bus_resolver
    import strength_pkg::*;
#(
    parameter int unsigned WIDTH            = 8,
    parameter int unsigned N_DRV            = 4,
    parameter int unsigned KEEPER           = 1,
    parameter int unsigned CONTENTION_LIMIT = 4,
    parameter int unsigned CNT_W            = $clog2(CONTENTION_LIMIT + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_DRV-1:0]            drv_en,
    input  logic [N_DRV*WIDTH-1:0]      drv_val,
    input  logic [N_DRV*STRENGTH_W-1:0] drv_s0,
    input  logic [N_DRV*STRENGTH_W-1:0] drv_s1,
    input  logic                        clr_fault,
    output logic [WIDTH-1:0]            bus_q,
    output logic [WIDTH-1:0]            bus_x,
    output logic [WIDTH-1:0]            bus_z,
    output logic                        contention,
    output logic                        fault,
    output logic [CNT_W-1:0]            contention_cnt
);

    localparam logic [CNT_W-1:0] LIMIT_C    = CNT_W'(CONTENTION_LIMIT);
    localparam logic [CNT_W-1:0] LIMIT_M1_C = CNT_W'(CONTENTION_LIMIT - 1);

    logic [WIDTH-1:0] drive1;
    logic [WIDTH-1:0] conflict;
    logic [WIDTH-1:0] undriven;
    logic [WIDTH-1:0] q_nxt;

    fsm_e             state;
    fsm_e             state_nxt;
    logic [CNT_W-1:0] cnt_nxt;

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        logic [N_DRV-1:0] bit_val;

        for (genvar d = 0; d < N_DRV; d++) begin : g_gather
            assign bit_val[d] = drv_val[d*WIDTH + b];
        end

        strength_bit_resolver #(
            .N_DRV (N_DRV)
        ) u_res (
            .val      (bit_val),
            .s0       (drv_s0),
            .s1       (drv_s1),
            .en       (drv_en),
            .drive1   (drive1[b]),
            .conflict (conflict[b]),
            .undriven (undriven[b])
        );

        // Conflicting bits hold; undriven bits hold or drop to 0 depending on KEEPER.
        assign q_nxt[b] = conflict[b] ? bus_q[b] :
                          undriven[b] ? ((KEEPER != 0) ? bus_q[b] : 1'b0) :
                          drive1[b];
    end

    // Resolved bus registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_q <= '0;
            bus_x <= '0;
            bus_z <= '1;
        end else begin
            bus_q <= q_nxt;
            bus_x <= conflict;
            bus_z <= undriven;
        end
    end

    assign contention = |bus_x;

    // Monitor state and consecutive-conflict counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= OK;
            contention_cnt <= '0;
        end else begin
            state          <= state_nxt;
            contention_cnt <= cnt_nxt;
        end
    end

    // Next-state: count registered conflict cycles, latch FAULT until cleared.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = contention_cnt;
        case (state)
            OK: begin
                if (contention) begin
                    if (CONTENTION_LIMIT == 1) begin
                        state_nxt = FAULT;
                        cnt_nxt   = LIMIT_C;
                    end else begin
                        state_nxt = CONTEND;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            CONTEND: begin
                if (!contention) begin
                    state_nxt = OK;
                    cnt_nxt   = '0;
                end else if (contention_cnt == LIMIT_M1_C) begin
                    state_nxt = FAULT;
                    cnt_nxt   = LIMIT_C;
                end else begin
                    cnt_nxt = contention_cnt + CNT_W'(1);
                end
            end
            FAULT: begin
                if (clr_fault) begin
                    state_nxt = OK;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = LIMIT_C;
                end
            end
            default: begin
                state_nxt = OK;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs decoded from the state register.
    always_comb begin
        fault = (state == FAULT);
    end

endmodule
